// File: rtl/sched_pkg.sv
// Shared types and default sizing for the hardware process scheduler.
package sched_pkg;

    localparam int NPROC_DEFAULT  = 8;
    localparam int PROC_W_DEFAULT = 3;

    typedef enum logic [1:0] {
        SLOT_FREE    = 2'd0,
        SLOT_READY   = 2'd1,
        SLOT_BLOCKED = 2'd2,
        SLOT_RUNNING = 2'd3
    } slot_state_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_SAVE   = 3'd2,
        ST_SELECT = 3'd3,
        ST_LOAD   = 3'd4
    } fsm_t;

endpackage

// File: rtl/process_scheduler_rr_pick.sv
// Rotating-priority finder: first set bit of ready_mask at or after start_idx, wrapping.
module rr_pick #(
    parameter int NPROC  = 8,
    parameter int PROC_W = 3
) (
    input  logic [NPROC-1:0]  ready_mask,
    input  logic [PROC_W-1:0] start_idx,
    output logic              found,
    output logic [PROC_W-1:0] idx
);

    logic [PROC_W-1:0] cand_s;

    // Scan from the farthest offset down so the nearest ready slot wins.
    always_comb begin
        found  = 1'b0;
        idx    = start_idx;
        cand_s = start_idx;
        for (int i = NPROC - 1; i >= 0; i--) begin
            cand_s = start_idx + PROC_W'(i);
            if (ready_mask[cand_s]) begin
                found = 1'b1;
                idx   = cand_s;
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/process_scheduler.sv
// Round-robin hardware process scheduler: slot table, quantum counter and switch FSM.
module process_scheduler
    import sched_pkg::*;
#(
    parameter int NPROC   = NPROC_DEFAULT,
    parameter int PROC_W  = PROC_W_DEFAULT,
    parameter int PC_W    = 32,
    parameter int QUANTUM = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              retire,
    input  logic [PC_W-1:0]   pc_in,
    input  logic              create_valid,
    input  logic [PROC_W-1:0] create_id,
    input  logic [PC_W-1:0]   create_pc,
    input  logic              proc_end,
    input  logic              io_block,
    input  logic              io_done_valid,
    input  logic [PROC_W-1:0] io_done_id,
    output logic              hold,
    output logic              switch_valid,
    output logic [PC_W-1:0]   next_pc,
    output logic [PROC_W-1:0] cur_proc,
    output logic              running,
    output logic              err
);

    localparam int QW = (QUANTUM > 2) ? $clog2(QUANTUM) : 1;
    localparam logic [QW-1:0] QLAST = QW'(QUANTUM - 1);

    slot_state_t       slot_state_r [NPROC];
    logic [PC_W-1:0]   saved_pc_r   [NPROC];
    fsm_t              state_r, next_state_s;
    logic [QW-1:0]     qcnt_r;
    logic [PROC_W-1:0] cur_proc_r;
    slot_state_t       save_kind_r, event_kind_s;
    logic [PC_W-1:0]   next_pc_r;
    logic              hold_r, switch_valid_r, running_r, err_r;
    logic [NPROC-1:0]  ready_s;
    logic              event_s, err_s, pick_found_s;
    logic [PROC_W-1:0] pick_idx_s;

    // Ready mask for the priority finder.
    always_comb begin
        ready_s = '0;
        for (int i = 0; i < NPROC; i++) begin
            ready_s[i] = (slot_state_r[i] == SLOT_READY);
        end
    end

    rr_pick #(.NPROC(NPROC), .PROC_W(PROC_W)) u_pick (
        .ready_mask (ready_s),
        .start_idx  (cur_proc_r + PROC_W'(1)),
        .found      (pick_found_s),
        .idx        (pick_idx_s)
    );

    // Slice-ending event detection; proc_end outranks io_block outranks expiry.
    always_comb begin
        event_s      = 1'b0;
        event_kind_s = SLOT_READY;
        if (state_r == ST_RUN && retire) begin
            event_s = proc_end || io_block || (qcnt_r == QLAST);
        end else begin
            event_s = 1'b0;
        end
        if (proc_end) begin
            event_kind_s = SLOT_FREE;
        end else if (io_block) begin
            event_kind_s = SLOT_BLOCKED;
        end else begin
            event_kind_s = SLOT_READY;
        end
    end

    // Illegal external commands: create to a non-FREE slot, io_done to a non-BLOCKED slot.
    always_comb begin
        err_s = 1'b0;
        if (create_valid && slot_state_r[create_id] != SLOT_FREE) begin
            err_s = 1'b1;
        end else begin
            err_s = 1'b0;
        end
        if (io_done_valid && slot_state_r[io_done_id] != SLOT_BLOCKED) begin
            err_s = 1'b1;
        end else begin
            err_s = err_s;
        end
    end

    // Next-state logic for the switch sequence.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE:   if (enable && (|ready_s)) next_state_s = ST_SELECT; else next_state_s = ST_IDLE;
            ST_RUN:    if (event_s) next_state_s = ST_SAVE; else next_state_s = ST_RUN;
            ST_SAVE:   if (enable) next_state_s = ST_SELECT; else next_state_s = ST_IDLE;
            ST_SELECT: if (pick_found_s) next_state_s = ST_LOAD; else next_state_s = ST_IDLE;
            ST_LOAD:   next_state_s = ST_RUN;
            default:   next_state_s = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Registered outputs, quantum counter and selection latch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_r         <= 1'b0;
            switch_valid_r <= 1'b0;
            running_r      <= 1'b0;
            err_r          <= 1'b0;
            next_pc_r      <= '0;
            cur_proc_r     <= '0;
            qcnt_r         <= '0;
            save_kind_r    <= SLOT_FREE;
        end else begin
            hold_r         <= (next_state_s == ST_SAVE) || (next_state_s == ST_SELECT);
            switch_valid_r <= (next_state_s == ST_LOAD);
            running_r      <= (next_state_s == ST_RUN);
            err_r          <= err_s;
            if (event_s) begin
                save_kind_r <= event_kind_s;
            end
            if (state_r == ST_SELECT && pick_found_s) begin
                cur_proc_r <= pick_idx_s;
                next_pc_r  <= saved_pc_r[pick_idx_s];
            end
            if (state_r == ST_LOAD || event_s) begin
                qcnt_r <= '0;
            end else if (state_r == ST_RUN && retire) begin
                qcnt_r <= qcnt_r + QW'(1);
            end
        end
    end

    // Slot table; FSM and command writes never target the same slot in one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NPROC; i++) begin
                slot_state_r[i] <= SLOT_FREE;
                saved_pc_r[i]   <= '0;
            end
        end else begin
            if (create_valid && slot_state_r[create_id] == SLOT_FREE) begin
                slot_state_r[create_id] <= SLOT_READY;
                saved_pc_r[create_id]   <= create_pc;
            end
            if (io_done_valid && slot_state_r[io_done_id] == SLOT_BLOCKED) begin
                slot_state_r[io_done_id] <= SLOT_READY;
            end
            if (state_r == ST_SAVE) begin
                slot_state_r[cur_proc_r] <= save_kind_r;
                saved_pc_r[cur_proc_r]   <= pc_in;
            end
            if (state_r == ST_LOAD) begin
                slot_state_r[cur_proc_r] <= SLOT_RUNNING;
            end
        end
    end

    assign hold         = hold_r;
    assign switch_valid = switch_valid_r;
    assign next_pc      = next_pc_r;
    assign cur_proc     = cur_proc_r;
    assign running      = running_r;
    assign err          = err_r;

endmodule

// File: tb/tb_process_scheduler.sv
// Self-checking bench for process_scheduler against a slot-table reference model.
module tb_process_scheduler;

    localparam int NP = 8;
    localparam int Q  = 16;
    localparam int M_FREE = 0, M_READY = 1, M_BLOCKED = 2, M_RUN = 3;

    logic        clk = 1'b0, reset, enable, retire, create_valid, proc_end, io_block, io_done_valid;
    logic [31:0] pc_in, create_pc, next_pc;
    logic [2:0]  create_id, io_done_id, cur_proc;
    logic        hold, switch_valid, running, err;

    int checks = 0, errors = 0;

    int          m_st [NP];
    logic [31:0] m_pc [NP];
    int          m_cur;
    bit          m_running;

    process_scheduler #(.NPROC(8), .PROC_W(3), .PC_W(32), .QUANTUM(Q)) dut (
        .clk(clk), .reset(reset), .enable(enable), .retire(retire), .pc_in(pc_in),
        .create_valid(create_valid), .create_id(create_id), .create_pc(create_pc),
        .proc_end(proc_end), .io_block(io_block), .io_done_valid(io_done_valid),
        .io_done_id(io_done_id), .hold(hold), .switch_valid(switch_valid), .next_pc(next_pc),
        .cur_proc(cur_proc), .running(running), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    task automatic m_reset();
        for (int i = 0; i < NP; i++) begin m_st[i] = M_FREE; m_pc[i] = 32'd0; end
        m_cur = 0;
        m_running = 1'b0;
    endtask

    function automatic int m_pick();
        for (int k = 1; k <= NP; k++) begin
            if (m_st[(m_cur + k) % NP] == M_READY) return (m_cur + k) % NP;
        end
        return -1;
    endfunction

    task automatic m_create(input int id, input logic [31:0] pc, output bit exp_err);
        exp_err = (m_st[id] != M_FREE);
        if (!exp_err) begin m_st[id] = M_READY; m_pc[id] = pc; end
    endtask

    task automatic m_iodone(input int id, output bit exp_err);
        exp_err = (m_st[id] != M_BLOCKED);
        if (!exp_err) m_st[id] = M_READY;
    endtask

    task automatic m_event(input bit endp, input bit iob, input logic [31:0] pcv, output int exp_id);
        m_st[m_cur] = endp ? M_FREE : (iob ? M_BLOCKED : M_READY);
        m_pc[m_cur] = pcv;
        exp_id = m_pick();
        if (exp_id >= 0) begin m_cur = exp_id; m_st[exp_id] = M_RUN; m_running = 1'b1; end
        else m_running = 1'b0;
    endtask

    task automatic m_start(output int exp_id);
        exp_id = m_pick();
        if (exp_id >= 0) begin m_cur = exp_id; m_st[exp_id] = M_RUN; m_running = 1'b1; end
    endtask

    // ---------------- stimulus drivers (no checking) ----------------
    task automatic do_create(input int id, input logic [31:0] pc, output logic e);
        create_valid = 1'b1; create_id = id[2:0]; create_pc = pc;
        tick();
        create_valid = 1'b0;
        e = err;
    endtask

    task automatic do_iodone(input int id, output logic e);
        io_done_valid = 1'b1; io_done_id = id[2:0];
        tick();
        io_done_valid = 1'b0;
        e = err;
    endtask

    task automatic wait_switch(output logic found, output logic [31:0] npc, output logic [2:0] np);
        found = 1'b0; npc = '0; np = '0;
        for (int c = 0; c < 8 && !found; c++) begin
            tick();
            if (switch_valid) begin found = 1'b1; npc = next_pc; np = cur_proc; end
        end
        tick();
    endtask

    task automatic drive_slice(input int nret, input bit endp, input bit iob, input logic [31:0] pcv,
                               output logic early, output logic h1, output logic h2,
                               output logic sw, output logic [31:0] npc, output logic [2:0] np);
        early = 1'b0;
        for (int i = 0; i < nret; i++) begin
            repeat ($urandom_range(0, 2)) begin
                tick();
                if (hold || switch_valid || !running) early = 1'b1;
            end
            retire = 1'b1;
            pc_in = (i == nret - 1) ? pcv : $urandom;
            proc_end = (i == nret - 1) && endp;
            io_block = (i == nret - 1) && iob;
            tick();
            retire = 1'b0; proc_end = 1'b0; io_block = 1'b0;
            if (i != nret - 1 && (hold || switch_valid)) early = 1'b1;
        end
        h1 = hold;
        tick();
        h2 = hold;
        tick();
        sw = switch_valid; npc = next_pc; np = cur_proc;
        tick();
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        m_reset();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        apply_reset();
        checks++;
        if ({hold, switch_valid, running, err} !== 4'b0000 || next_pc !== 32'd0 || cur_proc !== 3'd0) begin
            errors++;
            $display("FAIL reset_outputs got hold=%b sv=%b run=%b err=%b pc=%h cur=%0d want all zero",
                     hold, switch_valid, running, err, next_pc, cur_proc);
        end
    endtask

    task automatic test_basic();
        logic e, f, early, h1, h2, sw; logic [31:0] npc; logic [2:0] np; bit xe; int id;
        enable = 1'b1;
        m_create(0, 32'h100, xe);
        do_create(0, 32'h100, e);
        m_start(id);
        wait_switch(f, npc, np);
        checks++;
        if (f !== 1'b1 || npc !== 32'h100 || np !== 3'd0) begin
            errors++; $display("FAIL first_load got sv=%b pc=%h id=%0d want 1 100 0", f, npc, np);
        end
        checks++;
        if (running !== 1'b1) begin errors++; $display("FAIL running_after_load got %b want 1", running); end
        m_create(1, 32'h200, xe);
        do_create(1, 32'h200, e);
        checks++;
        if (e !== 1'b0) begin errors++; $display("FAIL create_ok_err got %b want 0", e); end
        drive_slice(Q, 1'b0, 1'b0, 32'h1F0, early, h1, h2, sw, npc, np);
        m_event(1'b0, 1'b0, 32'h1F0, id);
        checks++;
        if (early !== 1'b0 || h1 !== 1'b1 || h2 !== 1'b1) begin
            errors++; $display("FAIL quantum_timing got early=%b h1=%b h2=%b want 0 1 1", early, h1, h2);
        end
        checks++;
        if (sw !== 1'b1 || npc !== 32'h200 || np !== 3'd1) begin
            errors++; $display("FAIL expiry_switch got sv=%b pc=%h id=%0d want 1 200 1", sw, npc, np);
        end
    endtask

    task automatic test_io_block();
        logic e, early, h1, h2, sw; logic [31:0] npc; logic [2:0] np; bit xe; int id;
        drive_slice(5, 1'b0, 1'b1, 32'h205, early, h1, h2, sw, npc, np);
        m_event(1'b0, 1'b1, 32'h205, id);
        checks++;
        if (sw !== 1'b1 || npc !== 32'h1F0 || np !== 3'd0) begin
            errors++; $display("FAIL io_block_switch got sv=%b pc=%h id=%0d want 1 1f0 0", sw, npc, np);
        end
        m_iodone(1, xe);
        do_iodone(1, e);
        checks++;
        if (e !== 1'b0) begin errors++; $display("FAIL io_done_ok_err got %b want 0", e); end
        drive_slice(Q, 1'b0, 1'b0, 32'h0F8, early, h1, h2, sw, npc, np);
        m_event(1'b0, 1'b0, 32'h0F8, id);
        checks++;
        if (sw !== 1'b1 || npc !== 32'h205 || np !== 3'd1) begin
            errors++; $display("FAIL resume_after_io got sv=%b pc=%h id=%0d want 1 205 1", sw, npc, np);
        end
    endtask

    task automatic test_end_and_single();
        logic e, f, early, h1, h2, sw; logic [31:0] npc; logic [2:0] np; bit xe; int id;
        drive_slice(3, 1'b1, 1'b1, 32'h2AA, early, h1, h2, sw, npc, np);
        m_event(1'b1, 1'b1, 32'h2AA, id);
        checks++;
        if (sw !== 1'b1 || npc !== 32'h0F8 || np !== 3'd0) begin
            errors++; $display("FAIL end_io_switch got sv=%b pc=%h id=%0d want 1 f8 0", sw, npc, np);
        end
        m_iodone(1, xe);
        do_iodone(1, e);
        checks++;
        if (e !== 1'b1) begin errors++; $display("FAIL end_beats_io got err=%b want 1", e); end
        drive_slice(2, 1'b1, 1'b0, 32'h0FC, early, h1, h2, sw, npc, np);
        m_event(1'b1, 1'b0, 32'h0FC, id);
        checks++;
        if (sw !== 1'b0 || running !== 1'b0 || hold !== 1'b0) begin
            errors++; $display("FAIL none_ready_idle got sv=%b run=%b hold=%b want 0 0 0", sw, running, hold);
        end
        m_create(3, 32'h300, xe);
        do_create(3, 32'h300, e);
        m_start(id);
        wait_switch(f, npc, np);
        checks++;
        if (f !== 1'b1 || npc !== 32'h300 || np !== 3'd3) begin
            errors++; $display("FAIL idle_restart got sv=%b pc=%h id=%0d want 1 300 3", f, npc, np);
        end
        for (int r = 0; r < 2; r++) begin
            drive_slice(Q, 1'b0, 1'b0, 32'h3A0 + r, early, h1, h2, sw, npc, np);
            m_event(1'b0, 1'b0, 32'h3A0 + r, id);
            checks++;
            if (early !== 1'b0 || sw !== 1'b1 || npc !== 32'h3A0 + r || np !== 3'd3) begin
                errors++;
                $display("FAIL single_reselect got early=%b sv=%b pc=%h id=%0d want 0 1 %h 3",
                         early, sw, npc, np, 32'h3A0 + r);
            end
        end
    endtask

    task automatic test_errors();
        logic e, early, h1, h2, sw; logic [31:0] npc; logic [2:0] np; bit xe; int id;
        m_create(3, 32'hBAD, xe);
        do_create(3, 32'hBAD, e);
        checks++;
        if (e !== 1'b1) begin errors++; $display("FAIL create_running_err got %b want 1", e); end
        m_create(4, 32'h400, xe);
        do_create(4, 32'h400, e);
        m_create(4, 32'h999, xe);
        do_create(4, 32'h999, e);
        checks++;
        if (e !== 1'b1) begin errors++; $display("FAIL create_ready_err got %b want 1", e); end
        tick();
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL err_single_pulse got %b want 0", err); end
        m_iodone(6, xe);
        do_iodone(6, e);
        checks++;
        if (e !== 1'b1) begin errors++; $display("FAIL iodone_free_err got %b want 1", e); end
        drive_slice(Q, 1'b0, 1'b0, 32'h3C0, early, h1, h2, sw, npc, np);
        m_event(1'b0, 1'b0, 32'h3C0, id);
        checks++;
        if (sw !== 1'b1 || npc !== 32'h400 || np !== 3'd4) begin
            errors++; $display("FAIL table_unchanged got sv=%b pc=%h id=%0d want 1 400 4", sw, npc, np);
        end
    endtask

    task automatic test_random();
        logic e, f, early, h1, h2, sw; logic [31:0] npc, pcv; logic [2:0] np;
        bit xe, endp, iob; int id, op, n;
        for (int it = 0; it < 60; it++) begin
            op = m_running ? $urandom_range(0, 3) : $urandom_range(0, 1);
            id = $urandom_range(0, NP - 1);
            pcv = $urandom;
            if (op == 0) begin
                m_create(id, pcv, xe);
                do_create(id, pcv, e);
                checks++;
                if (e !== xe) begin errors++; $display("FAIL rnd_create_err slot=%0d got %b want %b", id, e, xe); end
            end else if (op == 1) begin
                m_iodone(id, xe);
                do_iodone(id, e);
                checks++;
                if (e !== xe) begin errors++; $display("FAIL rnd_iodone_err slot=%0d got %b want %b", id, e, xe); end
            end else begin
                n = $urandom_range(0, 2);
                endp = (n == 0) || ($urandom_range(0, 3) == 0 && n == 1);
                iob = (n == 1);
                if (!endp && !iob) begin
                    drive_slice(Q, 1'b0, 1'b0, pcv, early, h1, h2, sw, npc, np);
                end else begin
                    drive_slice($urandom_range(1, Q - 1), endp, iob, pcv, early, h1, h2, sw, npc, np);
                end
                m_event(endp, iob, pcv, id);
                checks++;
                if (early !== 1'b0 || sw !== (id >= 0) || running !== (id >= 0) ||
                    (id >= 0 && (npc !== m_pc[id] || np !== id[2:0]))) begin
                    errors++;
                    $display("FAIL rnd_event got early=%b sv=%b run=%b pc=%h id=%0d want sv=%b pc=%h id=%0d",
                             early, sw, running, npc, np, id >= 0, (id >= 0) ? m_pc[id] : 32'd0, id);
                end
            end
            if (!m_running && m_pick() >= 0) begin
                m_start(id);
                wait_switch(f, npc, np);
                checks++;
                if (f !== 1'b1 || npc !== m_pc[id] || np !== id[2:0]) begin
                    errors++; $display("FAIL rnd_idle_start got sv=%b pc=%h id=%0d want 1 %h %0d",
                                       f, npc, np, m_pc[id], id);
                end
            end
        end
    endtask

    task automatic test_reset_mid_switch();
        logic e, f; logic [31:0] npc; logic [2:0] np; bit xe, seen; int id;
        apply_reset();
        m_create(2, 32'h222, xe);
        do_create(2, 32'h222, e);
        m_start(id);
        wait_switch(f, npc, np);
        for (int i = 0; i < Q; i++) begin
            retire = 1'b1; pc_in = $urandom;
            tick();
        end
        retire = 1'b0;
        tick();
        checks++;
        if (hold !== 1'b1) begin errors++; $display("FAIL select_hold got %b want 1", hold); end
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({hold, switch_valid, running, err} !== 4'b0000 || next_pc !== 32'd0 || cur_proc !== 3'd0) begin
            errors++;
            $display("FAIL mid_reset_outputs got hold=%b sv=%b run=%b err=%b pc=%h cur=%0d want all zero",
                     hold, switch_valid, running, err, next_pc, cur_proc);
        end
        tick();
        reset = 1'b0;
        m_reset();
        seen = 1'b0;
        repeat (10) begin tick(); if (switch_valid) seen = 1'b1; end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL no_switch_after_reset got %b want 0", seen); end
        m_create(5, 32'h555, xe);
        do_create(5, 32'h555, e);
        m_start(id);
        wait_switch(f, npc, np);
        checks++;
        if (f !== 1'b1 || npc !== 32'h555 || np !== 3'd5) begin
            errors++; $display("FAIL post_reset_start got sv=%b pc=%h id=%0d want 1 555 5", f, npc, np);
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; retire = 1'b0; pc_in = '0;
        create_valid = 1'b0; create_id = '0; create_pc = '0;
        proc_end = 1'b0; io_block = 1'b0; io_done_valid = 1'b0; io_done_id = '0;
        test_reset();
        test_basic();
        test_io_block();
        test_end_and_single();
        test_errors();
        test_random();
        test_reset_mid_switch();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/process_scheduler.md
# process_scheduler

Hardware round-robin scheduler for the multiprogrammed single-cycle CPU. It keeps a per-process table of state and saved PC, and counts retired instructions against a quantum. On quantum expiry, process end or IO block it stalls the core, saves the PC, picks the next ready process and hands back the new PC and process id. The core uses that id for relative-address and branch correction. It sits between the instruction-fetch PC register and the process-base logic, replacing software-driven jumps to the scheduler routine.

## Interface
- NPROC, 8: process slots; power of two, ≥2
- PROC_W, 3: log2(NPROC)
- PC_W, 32: PC width
- QUANTUM, 16: retired instructions per time slice; ≥2
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- enable  in  1  scheduling allowed (low while BIOS runs)
- retire  in  1  one instruction completed this cycle
- pc_in  in  PC_W  PC of the next instruction of the running process
- create_valid  in  1  load a process into a slot
- create_id  in  PROC_W  slot to load
- create_pc  in  PC_W  start PC
- proc_end  in  1  running process finished (with retire)
- io_block  in  1  running process issued IO (with retire)
- io_done_valid  in  1  IO complete for a process
- io_done_id  in  PROC_W  process whose IO completed
- hold  out  1  core must freeze PC and register writes
- switch_valid  out  1  one-cycle pulse: load next_pc into the PC
- next_pc  out  PC_W  PC to resume
- cur_proc  out  PROC_W  running process id
- running  out  1  a process owns the core
- err  out  1  one-cycle pulse on an illegal command

## Operation
- Slot states: FREE, READY, BLOCKED, RUNNING. Table holds slot_state[NPROC] and saved_pc[NPROC].
- FSM states: IDLE, RUN, SAVE, SELECT, LOAD.
- IDLE: when enable is high and any slot is READY, go to SELECT.
- RUN: running=1. Each retire increments qcnt. An event is one of: retire with proc_end, retire with io_block, or retire with qcnt==QUANTUM-1. An event moves to SAVE.
- Event precedence within one cycle: proc_end > io_block > expiry.
- SAVE: hold=1. saved_pc[cur] <= pc_in. The current slot becomes FREE on proc_end, BLOCKED on io_block, READY on expiry. Then go to SELECT.
- SELECT: hold=1. Search rotating priority from cur_proc+1 mod NPROC, wrapping. The current slot may win last if it is READY.
  - If a slot is found, latch it and go to LOAD.
  - If none is found, go to IDLE with running=0 and hold=0.
- LOAD: switch_valid=1, next_pc=saved_pc[sel]. Slot becomes RUNNING, cur_proc<=sel, qcnt<=0, hold=0, then go to RUN.
- create_valid accepted in any state. A FREE slot becomes READY with saved_pc=create_pc. A non-FREE slot is ignored and err pulses.
- io_done_valid: a BLOCKED slot becomes READY. Any other slot is ignored and err pulses.
- enable low in RUN: the slice continues, but an event goes to SAVE then IDLE with no SELECT. IDLE does not leave until enable is high.
- All slot-state updates from external commands and from the FSM in the same cycle target different slots by construction. If a create targets the RUNNING slot, it is treated as non-FREE (err).

## Timing
- Reset values: all slots FREE, saved_pc 0, qcnt 0, FSM IDLE. hold=0, switch_valid=0, next_pc=0, cur_proc=0, running=0, err=0.
- Event cycle E (retire sampled) → SAVE at E+1 → SELECT at E+2 → LOAD at E+3. The core executes from next_pc at E+4.
- hold is high in E+1..E+2. switch_valid is high only in E+3.
- A slot made READY by create or io_done in cycle T is visible to SELECT from T+1.
- A quantum slice is exactly QUANTUM retires. Cycles without retire do not count.
- Reset asserted mid-switch clears everything immediately; no switch_valid after release.

## Structure
- Package sched_pkg holds: slot_state_t enum (FREE/READY/BLOCKED/RUNNING), fsm_t enum, and NPROC/PROC_W defaults.
- One sub-module, rr_pick: combinational rotating-priority finder. Inputs are a ready mask and a start index; outputs are found and idx.
- Table and FSM live in process_scheduler.

## Test plan
- Create slots 0 (pc 0x100) and 1 (pc 0x200), enable=1 → LOAD pulses next_pc=0x100, cur_proc=0. After 16 retires, switch_valid with next_pc=0x200, cur_proc=1.
- Proc 1 is running at retire 5 with io_block and pc_in=0x205 → slot 1 BLOCKED, switch to 0. io_done_id=1, then expiry of 0 → resume 0x205 on proc 1.
- Single process 3 expires → SELECT picks 3 again, switch_valid with the saved pc_in, qcnt restarts.
- proc_end and io_block in the same retire → slot FREE, not BLOCKED. With no READY slots → IDLE, running=0.
- create to a READY slot, and io_done to a FREE slot → err pulses once each, table unchanged.
- reset asserted in the SELECT cycle → all outputs at reset values, no switch_valid afterward until a new create.
